// File: rtl/spi_slave.sv
// SPI slave endpoint: receives one byte LSB-first on mosi, then returns one byte
// LSB-first on miso. sclk/cs/mosi are oversampled on clk through equal-depth synchronizers.
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs,
  input  logic       mosi,
  input  logic [7:0] tx_data,
  output logic       miso,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       done,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, RECV, SEND, WAIT_CS} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic       sclk_s, cs_s, mosi_s, sclk_prev;
  logic       rise, fall;
  logic [2:0] cnt;
  logic [7:0] tx_shift, rx_shift, rx_word;
  logic       cap_tx, rx_en, rx_last, tx_en, clr, done_set;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_prev;
  assign fall   = ~sclk_s & sclk_prev;
  assign busy   = (state != IDLE);

  // Synchronizer stage; cs idles high so its chain resets to 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    cap_tx       = 1'b0;
    rx_en        = 1'b0;
    rx_last      = 1'b0;
    tx_en        = 1'b0;
    clr          = 1'b0;
    done_set     = 1'b0;
    rx_word      = rx_shift;
    rx_word[cnt] = mosi_s;
    case (state)
      IDLE: begin
        clr = 1'b1;
        if (!cs_s) begin
          cap_tx    = 1'b1;
          state_nxt = RECV;
        end
      end
      RECV: begin
        if (cs_s) begin
          clr       = 1'b1;
          state_nxt = IDLE;
        end else if (fall) begin
          if (cnt == 3'd7) begin
            rx_last   = 1'b1;
            state_nxt = SEND;
          end else begin
            rx_en = 1'b1;
          end
        end
      end
      SEND: begin
        if (cs_s) begin
          clr       = 1'b1;
          state_nxt = IDLE;
        end else if (rise) begin
          tx_en = 1'b1;
          if (cnt == 3'd7) state_nxt = WAIT_CS;
        end
      end
      WAIT_CS: begin
        if (cs_s) begin
          done_set  = 1'b1;
          clr       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift/output stage: outputs land one clk after the synced edge strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
    end else begin
      rx_valid <= rx_last;
      done     <= done_set;
      if (cap_tx) tx_shift <= tx_data;
      if (clr) begin
        miso <= 1'b0;
        cnt  <= '0;
      end else if (rx_en) begin
        rx_shift <= rx_word;
        cnt      <= cnt + 3'd1;
      end else if (rx_last) begin
        rx_shift <= rx_word;
        rx_data  <= rx_word;
        cnt      <= '0;
      end else if (tx_en) begin
        miso <= tx_shift[cnt];
        cnt  <= cnt + 3'd1;
      end
    end
  end

endmodule
